// File: rtl/store_monitor.sv
// Store-bus checker: logs every RUN-state store into a trace FIFO and holds a
// sticky PASS / FAIL / TIMEOUT verdict until reset.
module store_monitor #(
   parameter logic [31:0] PASS_ADR    = 32'd100,
   parameter logic [31:0] PASS_DATA   = 32'd7,
   parameter logic [31:0] ALLOWED_ADR = 32'd96,
   parameter int          DEPTH       = 8,
   parameter int          TIMEOUT_CYC = 1000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemWrite,
   input  logic [31:0]              Adr,
   input  logic [31:0]              WriteData,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [31:0]              rd_adr,
   output logic [31:0]              rd_data,
   output logic [$clog2(DEPTH):0]   trace_cnt,
   output logic                     overflow,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic                     timeout,
   output logic [31:0]              fail_data
);

   // state    | meaning
   // S_RUN    | watching stores, cycle counter advancing on idle cycles
   // S_PASS   | saw PASS_DATA stored to PASS_ADR
   // S_FAIL   | saw a store to an illegal address or bad terminal data
   // S_TMO    | TIMEOUT_CYC idle RUN cycles elapsed without a verdict
   typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CW-1:0] TMR_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   state_t          state_q;
   logic [CW-1:0]   tmr_q;
   logic            done_q, pass_q, fail_q, timeout_q;
   logic [31:0]     fail_data_q;

   logic [63:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     cnt_q, cnt_d;
   logic            overflow_q, rd_valid_q;
   logic [31:0]     rd_adr_q, rd_data_q;

   logic run, push, pop, full, push_ok;

   always_comb begin
      run     = (state_q == S_RUN);
      push    = run & MemWrite;
      full    = (cnt_q == FULL_CNT);
      pop     = rd_en & (cnt_q != '0);
      // a full FIFO still accepts a push when a pop frees a slot on the same edge
      push_ok = push & (~full | pop);
      cnt_d   = cnt_q;
      if (push_ok && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop && !push_ok)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_RUN;
         tmr_q       <= '0;
         fail_data_q <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
         if (MemWrite) begin
            if (Adr == PASS_ADR && WriteData == PASS_DATA) begin
               state_q <= S_PASS;
               done_q  <= 1'b1;
               pass_q  <= 1'b1;
            end else if (Adr != ALLOWED_ADR) begin
               state_q     <= S_FAIL;
               fail_data_q <= WriteData;
               done_q      <= 1'b1;
               fail_q      <= 1'b1;
            end
         end else if (tmr_q == TMR_LAST) begin
            state_q   <= S_TMO;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
         end else begin
            tmr_q <= tmr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= {Adr, WriteData};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_adr_q   <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= pop;
         cnt_q      <= cnt_d;
         if (pop) begin
            rd_adr_q  <= mem_q[rd_ptr_q][63:32];
            rd_data_q <= mem_q[rd_ptr_q][31:0];
            rd_ptr_q  <= rd_ptr_q + 1'b1;
         end
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (push && !push_ok)
            overflow_q <= 1'b1;
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_adr    = rd_adr_q;
   assign rd_data   = rd_data_q;
   assign trace_cnt = cnt_q;
   assign overflow  = overflow_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = timeout_q;
   assign fail_data = fail_data_q;

endmodule

// File: tb/tb_store_monitor.sv
// Directed scenarios plus a randomized run, each cycle compared against a
// queue-based reference model of the store checker.
module tb_store_monitor;

   localparam int DEPTH = 4;
   localparam int TMO   = 20;
   localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2, V_TMO = 3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   MemWrite = 1'b0;
   logic [31:0]            Adr = '0;
   logic [31:0]            WriteData = '0;
   logic                   rd_en = 1'b0;
   logic                   rd_valid;
   logic [31:0]            rd_adr, rd_data, fail_data;
   logic [$clog2(DEPTH):0] trace_cnt;
   logic                   overflow, done, pass, fail, timeout;

   int checks = 0;
   int errors = 0;

   logic [63:0] mq[$];
   int          mv, mcnt;
   logic [31:0] mfd, mra, mrd;
   logic        mov, mrv;

   store_monitor #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
      .WriteData(WriteData), .rd_en(rd_en), .rd_valid(rd_valid),
      .rd_adr(rd_adr), .rd_data(rd_data), .trace_cnt(trace_cnt),
      .overflow(overflow), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .fail_data(fail_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic rd);
      logic [63:0] e;
      logic        do_pop;
      if (rst) begin
         mq.delete();
         mv = V_RUN; mcnt = 0; mfd = '0; mov = 1'b0;
         mrv = 1'b0; mra = '0; mrd = '0;
      end else begin
         do_pop = rd && (mq.size() != 0);
         mrv = do_pop;
         if (do_pop) begin
            e = mq.pop_front();
            mra = e[63:32];
            mrd = e[31:0];
         end
         if (mv == V_RUN && we) begin
            if (mq.size() < DEPTH) mq.push_back({a, d});
            else mov = 1'b1;
         end
         if (mv == V_RUN) begin
            if (we) begin
               if (a == 32'd100 && d == 32'd7) mv = V_PASS;
               else if (a != 32'd96) begin mv = V_FAIL; mfd = d; end
            end else if (mcnt == TMO - 1) mv = V_TMO;
            else mcnt++;
         end
      end
   endtask

   task automatic check_all();
      chk("m_trace_cnt", 64'(trace_cnt), 64'(mq.size()));
      chk("m_overflow",  64'(overflow),  64'(mov));
      chk("m_done",      64'(done),      64'(mv != V_RUN));
      chk("m_pass",      64'(pass),      64'(mv == V_PASS));
      chk("m_fail",      64'(fail),      64'(mv == V_FAIL));
      chk("m_timeout",   64'(timeout),   64'(mv == V_TMO));
      chk("m_fail_data", 64'(fail_data), 64'(mfd));
      chk("m_rd_valid",  64'(rd_valid),  64'(mrv));
      chk("m_rd_adr",    64'(rd_adr),    64'(mra));
      chk("m_rd_data",   64'(rd_data),   64'(mrd));
   endtask

   task automatic step(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rd);
      reset = rst; MemWrite = we; Adr = a; WriteData = d; rd_en = rd;
      @(posedge clk);
      model(rst, we, a, d, rd);
      #1;
      check_all();
      reset = 1'b0; MemWrite = 1'b0; rd_en = 1'b0;
   endtask

   task automatic rst_step();
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, a, d, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
   endtask

   initial begin
      logic        r_we, r_rd, r_rst;
      logic [31:0] r_a, r_d;
      int          sel;

      // reset state and the basic pass sequence
      rst_step();
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_cnt", 64'(trace_cnt), 64'd0);
      store(32'd96, 32'd3);
      store(32'd96, 32'd5);
      chk("s1_pass_early", 64'(pass), 64'd0);
      store(32'd100, 32'd7);
      chk("s1_pass", 64'(pass), 64'd1);
      chk("s1_cnt", 64'(trace_cnt), 64'd3);
      pop();
      chk("s1_pop0", {rd_adr, rd_data}, {32'd96, 32'd3});
      pop();
      chk("s1_pop1", {rd_adr, rd_data}, {32'd96, 32'd5});
      pop();
      chk("s1_pop2", {rd_adr, rd_data}, {32'd100, 32'd7});
      chk("s1_rv", 64'(rd_valid), 64'd1);
      idle();
      chk("s1_rv_once", 64'(rd_valid), 64'd0);

      // wrong data at the pass address
      rst_step();
      store(32'd100, 32'd6);
      chk("s2_fail", 64'(fail), 64'd1);
      chk("s2_fd", 64'(fail_data), 64'd6);
      chk("s2_pass", 64'(pass), 64'd0);
      store(32'd100, 32'd7);
      chk("s2_ignored", 64'(trace_cnt), 64'd1);
      chk("s2_still_pass0", 64'(pass), 64'd0);

      // illegal address
      rst_step();
      store(32'd104, 32'd7);
      chk("s3_fail", 64'(fail), 64'd1);
      chk("s3_fd", 64'(fail_data), 64'd7);

      // timeout boundary, then a store on the last cycle beats it
      rst_step();
      for (int i = 0; i < TMO - 1; i++) idle();
      chk("s4_tmo_early", 64'(timeout), 64'd0);
      idle();
      chk("s4_tmo", 64'(timeout), 64'd1);
      chk("s4_done", 64'(done), 64'd1);
      rst_step();
      for (int i = 0; i < TMO - 1; i++) idle();
      store(32'd100, 32'd7);
      chk("s4_pass", 64'(pass), 64'd1);
      chk("s4_no_tmo", 64'(timeout), 64'd0);
      idle();
      chk("s4_no_tmo2", 64'(timeout), 64'd0);

      // overflow keeps the oldest entries; push+pop when full keeps count
      rst_step();
      for (int i = 0; i < 6; i++) store(32'd96, 32'(i + 1));
      chk("s5_cnt", 64'(trace_cnt), 64'd4);
      chk("s5_ovf", 64'(overflow), 64'd1);
      step(1'b0, 1'b1, 32'd96, 32'd99, 1'b1);
      chk("s5_pp_cnt", 64'(trace_cnt), 64'd4);
      chk("s5_pop1", 64'(rd_data), 64'd1);
      for (int i = 2; i <= 4; i++) begin
         pop();
         chk("s5_popn", 64'(rd_data), 64'(i));
      end
      pop();
      chk("s5_pop_new", 64'(rd_data), 64'd99);

      // reset after a verdict; pop on empty FIFO
      store(32'd100, 32'd7);
      chk("s6_pass", 64'(pass), 64'd1);
      rst_step();
      chk("s6_pass0", 64'(pass), 64'd0);
      chk("s6_cnt0", 64'(trace_cnt), 64'd0);
      chk("s6_rd_adr0", 64'(rd_adr), 64'd0);
      pop();
      chk("s6_rv0", 64'(rd_valid), 64'd0);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         r_rst = ($urandom_range(0, 99) < 3);
         r_we  = ($urandom_range(0, 99) < 35);
         r_rd  = ($urandom_range(0, 99) < 30);
         sel   = $urandom_range(0, 99);
         if (sel < 85)      r_a = 32'd96;
         else if (sel < 92) r_a = 32'd100;
         else               r_a = $urandom_range(0, 200);
         r_d = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 15));
         step(r_rst, r_we, r_a, r_d, r_rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
